des_subkey_gen: RTL and testbench

- Sequential DES key schedule that streams the sixteen 48-bit round subkeys to the round datapath, one subkey per handshake.
- Supports the encrypt direction (K1..K16, left rotations) and the decrypt direction (K16..K1, right rotations).
- The decrypt direction is the reverse use of the same schedule that feeds the S-box round datapath, so one engine can serve both ciphers.
- Sits between key load and the round datapath; each subkey is XORed with the expanded R half before the S-boxes.

---
 rtl/des_pkg.sv | 47 ++++
 rtl/des_pc2.sv | 18 +
 rtl/des_subkey_gen.sv | 116 +++++++++++
 tb/tb_des_subkey_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers.
//   PC1_TAB / PC2_TAB : DES permutation tables, 1-based, MSB-first bit numbers
//   SHIFT_TAB         : per-round rotate amounts, index 0 is round 1
//   pc1()             : 64-bit key -> 56-bit {C0,D0}; parity bits dropped
//   rotl28()/rotr28() : rotate one 28-bit half by 1 or 2
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUND_W  = 4;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // DES bit n (1-based) of the key lives at key[64-n].
    function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [2*CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 2*CD_W; i++) begin
            r[6'(2*CD_W - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic two);
        return two ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic two);
        return two ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation, purely combinational.
//   cd     : {C,D}, cd[55] is DES bit 1 of C
//   subkey : 48-bit round subkey, subkey[47] is PC-2 output bit 1
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0]   cd,
    output logic [SUBKEY_W-1:0] subkey
);

    always_comb begin
        subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            subkey[6'(SUBKEY_W - 1 - i)] = cd[6'(2*CD_W - PC2_TAB[i])];
        end
    end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule: streams K1..K16 (encrypt) or K16..K1
// (decrypt), one subkey per valid/ready transfer.
//   i_clk, i_rst       : clock, async active-high reset
//   i_start/i_decrypt  : start request and direction, sampled only when idle
//   i_key              : 64-bit DES key, parity bits ignored
//   i_ready            : consumer accepts o_subkey
//   o_subkey/o_round   : presented subkey and its round index (0 = K1)
//   o_valid/o_busy     : schedule in progress
//   o_done             : one-cycle pulse after the last subkey is taken
//
// state | meaning
// IDLE  | waiting for i_start, outputs forced to zero
// RUN   | presenting subkey for round_q, advance on each transfer
module des_subkey_gen
    import des_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_decrypt,
    input  logic [KEY_W-1:0]    i_key,
    input  logic                i_ready,
    output logic [SUBKEY_W-1:0] o_subkey,
    output logic                o_valid,
    output logic [ROUND_W-1:0]  o_round,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic                  dec_q;
    logic [CD_W-1:0]       c_q;
    logic [CD_W-1:0]       d_q;
    logic [ROUND_W-1:0]    round_q;
    logic                  done_q;

    logic [2*CD_W-1:0]     key_cd;
    logic [ROUND_W-1:0]    sched_idx;
    logic                  shift_two;
    logic                  last_round;
    logic                  running;
    logic [SUBKEY_W-1:0]   pc2_out;

    assign key_cd  = pc1(i_key);
    assign running = (state == ST_RUN);

    // Encrypt moves C(r+1) -> C(r+2) using s[r+2]; decrypt undoes the shift
    // that produced C(r+1), i.e. s[r+1]. SHIFT_TAB is 0-based.
    assign sched_idx  = dec_q ? round_q : round_q + 4'd1;
    assign shift_two  = (SHIFT_TAB[sched_idx] == 2);
    assign last_round = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            dec_q   <= 1'b0;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        dec_q <= i_decrypt;
                        state <= ST_RUN;
                        if (i_decrypt) begin
                            // Total rotation over 16 rounds is 28, so C16/D16 equal C0/D0.
                            c_q     <= key_cd[2*CD_W-1:CD_W];
                            d_q     <= key_cd[CD_W-1:0];
                            round_q <= 4'd15;
                        end else begin
                            c_q     <= rotl28(key_cd[2*CD_W-1:CD_W], 1'b0);
                            d_q     <= rotl28(key_cd[CD_W-1:0], 1'b0);
                            round_q <= 4'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_ready) begin
                        if (last_round) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else if (dec_q) begin
                            c_q     <= rotr28(c_q, shift_two);
                            d_q     <= rotr28(d_q, shift_two);
                            round_q <= round_q - 4'd1;
                        end else begin
                            c_q     <= rotl28(c_q, shift_two);
                            d_q     <= rotl28(d_q, shift_two);
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (pc2_out)
    );

    // C/D keep the last run's material while idle; mask it off the outputs.
    assign o_subkey = running ? pc2_out : '0;
    assign o_round  = running ? round_q : '0;
    assign o_valid  = running;
    assign o_busy   = running;
    assign o_done   = done_q;

endmodule

// File: tb/tb_des_subkey_gen.sv
module tb_des_subkey_gen;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_decrypt = 1'b0;
    logic [63:0] i_key = '0;
    logic        i_ready = 1'b0;
    logic [47:0] o_subkey;
    logic        o_valid;
    logic [3:0]  o_round;
    logic        o_busy;
    logic        o_done;

    des_subkey_gen dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_decrypt (i_decrypt),
        .i_key     (i_key),
        .i_ready   (i_ready),
        .o_subkey  (o_subkey),
        .o_valid   (o_valid),
        .o_round   (o_round),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [63:0] KEY_EX  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_MSK = 64'h0101010101010101;

    logic [47:0] ex_keys [16];

    typedef struct packed {
        logic [3:0]  round;
        logic [47:0] subkey;
    } exp_t;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          ready_pct;
        int          kind;
        logic [47:0] exp_first;
        logic [47:0] exp_last;
    } vec_t;

    exp_t exp_q [$];
    vec_t vecs [7];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind 0: textbook key schedule, 1: all-zero key, 2: all-ones key
    function automatic logic [47:0] exp_key(input int kind, input int idx);
        if (kind == 1) return 48'h0;
        if (kind == 2) return {48{1'b1}};
        return ex_keys[idx];
    endfunction

    task automatic run_sched(input logic [63:0] key, input logic dec, input int ready_pct,
                             input int kind, input int poke_round, input int rst_round,
                             input bit chain, output logic [47:0] first_sk,
                             output logic [47:0] last_sk);
        int  cyc;
        int  idx;
        bit  poked;
        bit  rdy;
        bit  first_seen;
        poked      = 0;
        first_seen = 0;
        first_sk   = '0;
        last_sk    = '0;
        chk("start_busy_low", {63'b0, o_busy}, 64'd0);
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            idx = dec ? 15 - r : r;
            exp_q.push_back({idx[3:0], exp_key(kind, idx)});
        end
        i_key     = key;
        i_decrypt = dec;
        i_start   = 1'b1;
        i_ready   = 1'b0;
        @(negedge i_clk);
        i_start   = 1'b0;
        i_key     = ~key;
        i_decrypt = ~dec;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            chk("valid", {63'b0, o_valid}, 64'd1);
            chk("subkey", {16'b0, o_subkey}, {16'b0, exp_q[0].subkey});
            chk("round", {60'b0, o_round}, {60'b0, exp_q[0].round});
            if (!first_seen) begin
                first_sk   = o_subkey;
                first_seen = 1;
            end
            last_sk = o_subkey;
            if (rst_round >= 0 && exp_q[0].round == rst_round[3:0]) begin
                #2 i_rst = 1'b1;
                #1;
                chk("rst_valid", {63'b0, o_valid}, 64'd0);
                chk("rst_busy", {63'b0, o_busy}, 64'd0);
                chk("rst_subkey", {16'b0, o_subkey}, 64'd0);
                chk("rst_round", {60'b0, o_round}, 64'd0);
                @(negedge i_clk);
                chk("rst_no_done", {63'b0, o_done}, 64'd0);
                i_rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (poke_round >= 0 && !poked && o_round == poke_round[3:0]) begin
                i_start   = 1'b1;
                i_key     = 64'h0F1E2D3C4B5A6978;
                i_decrypt = ~dec;
                poked     = 1;
            end else begin
                i_start = 1'b0;
            end
            rdy     = ($urandom_range(99) < ready_pct);
            i_ready = rdy;
            @(negedge i_clk);
            if (rdy) void'(exp_q.pop_front());
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'b0;
        if (cyc >= 400) begin
            chk("timeout", 64'(exp_q.size()), 64'd0);
            return;
        end
        chk("done_pulse", {63'b0, o_done}, 64'd1);
        chk("end_valid", {63'b0, o_valid}, 64'd0);
        chk("end_subkey", {16'b0, o_subkey}, 64'd0);
        if (!chain) begin
            @(negedge i_clk);
            chk("done_one_cycle", {63'b0, o_done}, 64'd0);
        end
    endtask

    logic [47:0] f_sk, l_sk;

    initial begin
        ex_keys = '{
            48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
            48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
            48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
            48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
        };
        vecs[0] = '{KEY_EX,           1'b0, 100, 0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{KEY_EX,           1'b1, 100, 0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[2] = '{KEY_EX,           1'b0,  40, 0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[3] = '{KEY_EX ^ PAR_MSK, 1'b0, 100, 0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[4] = '{KEY_EX ^ PAR_MSK, 1'b1,  40, 0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[5] = '{64'h0,            1'b0, 100, 1, 48'h0,            48'h0};
        vecs[6] = '{~64'h0,           1'b1,  60, 2, {48{1'b1}},       {48{1'b1}}};

        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_valid", {63'b0, o_valid}, 64'd0);
        chk("reset_busy", {63'b0, o_busy}, 64'd0);
        chk("reset_done", {63'b0, o_done}, 64'd0);
        chk("reset_subkey", {16'b0, o_subkey}, 64'd0);
        chk("reset_round", {60'b0, o_round}, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int v = 0; v < 7; v++) begin
            run_sched(vecs[v].key, vecs[v].dec, vecs[v].ready_pct, vecs[v].kind,
                      -1, -1, 0, f_sk, l_sk);
            chk($sformatf("vec%0d_first", v), {16'b0, f_sk}, {16'b0, vecs[v].exp_first});
            chk($sformatf("vec%0d_last", v), {16'b0, l_sk}, {16'b0, vecs[v].exp_last});
        end

        // start pulse with another key at round 5 must be ignored
        run_sched(KEY_EX, 1'b0, 100, 0, 5, -1, 0, f_sk, l_sk);
        chk("poke_last", {16'b0, l_sk}, {16'b0, ex_keys[15]});

        // back-to-back: second start lands in the o_done cycle
        run_sched(KEY_EX, 1'b0, 100, 0, -1, -1, 1, f_sk, l_sk);
        run_sched(KEY_EX, 1'b1, 70, 0, -1, -1, 0, f_sk, l_sk);
        chk("b2b_first", {16'b0, f_sk}, {16'b0, ex_keys[15]});

        // asynchronous reset at round 7, then a clean restart
        run_sched(KEY_EX, 1'b0, 70, 0, -1, 7, 0, f_sk, l_sk);
        @(negedge i_clk);
        chk("post_rst_idle", {63'b0, o_busy}, 64'd0);
        run_sched(KEY_EX, 1'b0, 100, 0, -1, -1, 0, f_sk, l_sk);
        chk("post_rst_k1", {16'b0, f_sk}, {16'b0, ex_keys[0]});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
